// File: rtl/multi_tuner.sv
// multi_tuner: NCH independent NCO down-converters sharing one input stream.
// Each channel accumulates its own tuning word, optionally noise-shapes the
// phase truncation, looks up sin/cos from a shared quarter-wave table and
// mixes the common input sample. Configuration is double-buffered: writes
// land in shadow registers and a commit moves all channels at once on the
// next accepted input sample. Pipeline latency is a fixed 4 cycles.
module multi_tuner #(
  parameter int NCH = 4,
  parameter int DSZ = 16,
  parameter int FSZ = 26,
  parameter int PSZ = 12
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  input  logic signed [DSZ-1:0]                   in,
  input  logic                                    lo_ns_en,
  input  logic                                    cfg_wr,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0]  cfg_ch,
  input  logic [FSZ-1:0]                          cfg_freq,
  input  logic [PSZ-1:0]                          cfg_phase,
  input  logic                                    cfg_commit,
  input  logic                                    cfg_phs_rst,
  output logic                                    cfg_pending,
  output logic                                    out_valid,
  output logic [NCH*DSZ-1:0]                      out_i,
  output logic [NCH*DSZ-1:0]                      out_q
);

  localparam int  CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int  QN  = 2 ** (PSZ - 2);
  localparam int  LSZ = FSZ - PSZ;
  localparam real AMP = real'(2 ** (DSZ - 1) - 1);
  localparam real PI  = 3.14159265358979323846;

  localparam logic [DSZ-2:0]          FULL = '1;
  localparam logic signed [2*DSZ-1:0] RND  = (2*DSZ)'(1) << (DSZ - 2);
  localparam logic signed [2*DSZ-1:0] SMAX = (2*DSZ)'(2 ** (DSZ - 1) - 1);
  localparam logic signed [2*DSZ-1:0] SMIN = ~SMAX;

  // Quarter-wave sine entry k of QN, scaled to full positive amplitude.
  // Taylor series keeps the table a pure elaboration-time constant.
  function automatic int quarter_sin(input int k);
    real x;
    real term;
    real sum;
    x    = PI * real'(k) / (2.0 * real'(QN));
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(sum * AMP + 0.5);
  endfunction

  // Drop the DSZ-1 fraction bits with round-half-up, then clamp to DSZ bits.
  function automatic logic [DSZ-1:0] round_sat(input logic signed [2*DSZ-1:0] p);
    logic signed [2*DSZ-1:0] r;
    r = (p + RND) >>> (DSZ - 1);
    if (r > SMAX)      return SMAX[DSZ-1:0];
    else if (r < SMIN) return SMIN[DSZ-1:0];
    else               return r[DSZ-1:0];
  endfunction

  genvar gi;

  logic                  pend_reg;
  logic                  prst_reg;
  logic                  apply;
  logic [2:0]            v_reg;
  logic                  out_valid_reg;
  logic signed [DSZ-1:0] in_s1_reg;
  logic signed [DSZ-1:0] in_s2_reg;
  logic [DSZ-2:0]        qtab [QN];

  // A pending commit takes effect on the next accepted sample.
  assign apply       = pend_reg & in_valid;
  assign cfg_pending = pend_reg;
  assign out_valid   = out_valid_reg;

  // Commit request tracking; a commit on the applying cycle re-arms the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg <= 1'b0;
      prst_reg <= 1'b0;
    end else if (apply) begin
      pend_reg <= cfg_commit;
      prst_reg <= cfg_commit & cfg_phs_rst;
    end else if (cfg_commit) begin
      pend_reg <= 1'b1;
      prst_reg <= prst_reg | cfg_phs_rst;
    end
  end

  // Shared valid chain and input sample delay, common to all channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_reg         <= '0;
      out_valid_reg <= 1'b0;
      in_s1_reg     <= '0;
      in_s2_reg     <= '0;
    end else begin
      v_reg         <= {v_reg[1:0], in_valid};
      out_valid_reg <= v_reg[2];
      in_s1_reg     <= in;
      in_s2_reg     <= in_s1_reg;
    end
  end

  for (gi = 0; gi < QN; gi++) begin : g_qtab
    localparam int QV = quarter_sin(gi);
    assign qtab[gi] = QV[DSZ-2:0];
  end

  for (gi = 0; gi < NCH; gi++) begin : g_ch
    logic [FSZ-1:0]          shd_freq_reg;
    logic [FSZ-1:0]          act_freq_reg;
    logic [PSZ-1:0]          shd_phase_reg;
    logic [PSZ-1:0]          act_phase_reg;
    logic [FSZ-1:0]          acc_reg;
    logic [FSZ-1:0]          ns_reg;
    logic [FSZ-1:0]          acc_next;
    logic [FSZ-1:0]          ns_next;
    logic [FSZ-1:0]          dith;
    logic [PSZ-1:0]          phase_s1_reg;
    logic [1:0]              quad;
    logic [PSZ-3:0]          idx;
    logic [PSZ-3:0]          midx;
    logic [DSZ-2:0]          s_dir;
    logic [DSZ-2:0]          s_mir;
    logic [DSZ-2:0]          sin_mag_reg;
    logic [DSZ-2:0]          cos_mag_reg;
    logic                    sin_neg_reg;
    logic                    cos_neg_reg;
    logic signed [DSZ-1:0]   coef_i;
    logic signed [DSZ-1:0]   coef_q;
    logic signed [2*DSZ-1:0] prod_i_reg;
    logic signed [2*DSZ-1:0] prod_q_reg;
    logic [DSZ-1:0]          out_i_reg;
    logic [DSZ-1:0]          out_q_reg;

    // Truncation residue fed back as a signed value when shaping is enabled.
    assign dith     = {{PSZ{ns_reg[LSZ-1]}}, ns_reg[LSZ-1:0]};
    assign acc_next = (apply && prst_reg) ? '0 : acc_reg + act_freq_reg;
    assign ns_next  = (apply && prst_reg) ? '0 : acc_next + (lo_ns_en ? dith : '0);

    // Shadow writes and the all-channel shadow-to-active transfer.
    always_ff @(posedge clk) begin
      if (reset) begin
        shd_freq_reg  <= '0;
        shd_phase_reg <= '0;
        act_freq_reg  <= '0;
        act_phase_reg <= '0;
      end else begin
        if (cfg_wr && cfg_ch == CHW'(gi)) begin
          shd_freq_reg  <= cfg_freq;
          shd_phase_reg <= cfg_phase;
        end
        if (apply) begin
          act_freq_reg  <= shd_freq_reg;
          act_phase_reg <= shd_phase_reg;
        end
      end
    end

    // Stage 1: phase for this sample from current state, then advance NCO.
    always_ff @(posedge clk) begin
      if (reset) begin
        acc_reg      <= '0;
        ns_reg       <= '0;
        phase_s1_reg <= '0;
      end else if (in_valid) begin
        phase_s1_reg <= ns_reg[FSZ-1 -: PSZ] + act_phase_reg;
        acc_reg      <= acc_next;
        ns_reg       <= ns_next;
      end
    end

    // Quadrant folding: mirrored index QN-idx, with idx 0 meaning full scale.
    assign quad  = phase_s1_reg[PSZ-1 -: 2];
    assign idx   = phase_s1_reg[PSZ-3:0];
    assign midx  = -idx;
    assign s_dir = qtab[idx];
    assign s_mir = (idx == '0) ? FULL : qtab[midx];

    // Stage 2: registered table read of sin/cos magnitude and sign.
    always_ff @(posedge clk) begin
      if (reset) begin
        sin_mag_reg <= '0;
        cos_mag_reg <= '0;
        sin_neg_reg <= 1'b0;
        cos_neg_reg <= 1'b0;
      end else begin
        sin_mag_reg <= quad[0] ? s_mir : s_dir;
        cos_mag_reg <= quad[0] ? s_dir : s_mir;
        sin_neg_reg <= quad[1];
        cos_neg_reg <= quad[0] ^ quad[1];
      end
    end

    // In-phase uses +cos, quadrature uses -sin.
    assign coef_i = cos_neg_reg ? -$signed({1'b0, cos_mag_reg}) : $signed({1'b0, cos_mag_reg});
    assign coef_q = sin_neg_reg ? $signed({1'b0, sin_mag_reg}) : -$signed({1'b0, sin_mag_reg});

    // Stage 3: full-precision mixer products.
    always_ff @(posedge clk) begin
      if (reset) begin
        prod_i_reg <= '0;
        prod_q_reg <= '0;
      end else begin
        prod_i_reg <= (2*DSZ)'(in_s2_reg) * (2*DSZ)'(coef_i);
        prod_q_reg <= (2*DSZ)'(in_s2_reg) * (2*DSZ)'(coef_q);
      end
    end

    // Stage 4: round/saturate; outputs only move for valid samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        out_i_reg <= '0;
        out_q_reg <= '0;
      end else if (v_reg[2]) begin
        out_i_reg <= round_sat(prod_i_reg);
        out_q_reg <= round_sat(prod_q_reg);
      end
    end

    assign out_i[gi*DSZ +: DSZ] = out_i_reg;
    assign out_q[gi*DSZ +: DSZ] = out_q_reg;
  end

endmodule

// File: tb/tb_multi_tuner.sv
// tb_multi_tuner: directed scenarios followed by random traffic, every cycle
// compared against a sample-level reference model of the tuner bank.
module tb_multi_tuner;
  localparam int NCH = 4;
  localparam int DSZ = 16;
  localparam int FSZ = 26;
  localparam int PSZ = 12;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam longint FMASK = (64'sd1 <<< FSZ) - 1;
  localparam longint LMASK = (64'sd1 <<< (FSZ - PSZ)) - 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic signed [DSZ-1:0] in = '0;
  logic                  lo_ns_en = 1'b0;
  logic                  cfg_wr = 1'b0;
  logic [CHW-1:0]        cfg_ch = '0;
  logic [FSZ-1:0]        cfg_freq = '0;
  logic [PSZ-1:0]        cfg_phase = '0;
  logic                  cfg_commit = 1'b0;
  logic                  cfg_phs_rst = 1'b0;
  logic                  cfg_pending;
  logic                  out_valid;
  logic [NCH*DSZ-1:0]    out_i;
  logic [NCH*DSZ-1:0]    out_q;

  always #5 clk = ~clk;

  multi_tuner #(.NCH(NCH), .DSZ(DSZ), .FSZ(FSZ), .PSZ(PSZ)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .lo_ns_en(lo_ns_en),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase),
    .cfg_commit(cfg_commit), .cfg_phs_rst(cfg_phs_rst), .cfg_pending(cfg_pending),
    .out_valid(out_valid), .out_i(out_i), .out_q(out_q)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    n_cmp++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
    end
  endtask

  // Stimulus for the next clock edge; one-shot fields self-clear after use.
  bit     s_rst = 1'b1;
  bit     s_iv  = 1'b0;
  int     s_in  = 0;
  bit     s_ns  = 1'b0;
  bit     s_wr  = 1'b0;
  int     s_ch  = 0;
  longint s_f   = 0;
  int     s_p   = 0;
  bit     s_cm  = 1'b0;
  bit     s_pr  = 1'b0;

  // Reference model state.
  longint m_shd_f [NCH];
  longint m_act_f [NCH];
  longint m_acc   [NCH];
  longint m_ns    [NCH];
  int     m_shd_p [NCH];
  int     m_act_p [NCH];
  bit     m_pend;
  bit     m_prst;
  bit     ln_v [3];
  int     ln_i [3][NCH];
  int     ln_q [3][NCH];
  bit     m_ov;
  int     m_oi [NCH];
  int     m_oq [NCH];

  // Ideal mixer: x * (cos or -sin) * (2^(DSZ-1)-1)/2^(DSZ-1), rounded, clamped.
  function automatic int mix(input int x, input int ph, input bit quad);
    real a;
    real v;
    a = 2.0 * 3.14159265358979323846 * real'(ph) / real'(1 << PSZ);
    v = quad ? -$sin(a) : $cos(a);
    v = real'(x) * v * 32767.0 / 32768.0;
    v = $floor(v + 0.5);
    if (v > 32767.0)  v = 32767.0;
    if (v < -32768.0) v = -32768.0;
    return $rtoi(v);
  endfunction

  task automatic model_reset();
    m_pend = 1'b0;
    m_prst = 1'b0;
    m_ov   = 1'b0;
    for (int k = 0; k < 3; k++) ln_v[k] = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_shd_f[c] = 0; m_act_f[c] = 0; m_acc[c] = 0; m_ns[c] = 0;
      m_shd_p[c] = 0; m_act_p[c] = 0; m_oi[c] = 0; m_oq[c] = 0;
      for (int k = 0; k < 3; k++) begin ln_i[k][c] = 0; ln_q[k][c] = 0; end
    end
  endtask

  task automatic model_step();
    bit     apply;
    int     ph;
    longint lo;
    if (s_rst) begin
      model_reset();
      return;
    end
    apply = m_pend && s_iv;
    // Output register takes the sample accepted four edges earlier.
    m_ov = ln_v[2];
    if (ln_v[2]) begin
      for (int c = 0; c < NCH; c++) begin m_oi[c] = ln_i[2][c]; m_oq[c] = ln_q[2][c]; end
    end
    for (int k = 2; k > 0; k--) begin
      ln_v[k] = ln_v[k-1];
      for (int c = 0; c < NCH; c++) begin ln_i[k][c] = ln_i[k-1][c]; ln_q[k][c] = ln_q[k-1][c]; end
    end
    ln_v[0] = s_iv;
    if (s_iv) begin
      for (int c = 0; c < NCH; c++) begin
        ph = int'(((m_ns[c] >> (FSZ - PSZ)) + longint'(m_act_p[c])) % longint'(1 << PSZ));
        ln_i[0][c] = mix(s_in, ph, 1'b0);
        ln_q[0][c] = mix(s_in, ph, 1'b1);
        if (apply && m_prst) begin
          m_acc[c] = 0;
          m_ns[c]  = 0;
        end else begin
          m_acc[c] = (m_acc[c] + m_act_f[c]) & FMASK;
          lo = m_ns[c] & LMASK;
          if (lo > LMASK / 2) lo = lo - (LMASK + 1);
          m_ns[c] = (m_acc[c] + (s_ns ? lo : 64'sd0)) & FMASK;
        end
      end
    end
    if (apply) begin
      for (int c = 0; c < NCH; c++) begin m_act_f[c] = m_shd_f[c]; m_act_p[c] = m_shd_p[c]; end
    end
    if (s_wr && s_ch < NCH) begin
      m_shd_f[s_ch] = s_f & FMASK;
      m_shd_p[s_ch] = s_p % (1 << PSZ);
    end
    if (apply) begin
      m_pend = s_cm;
      m_prst = s_cm && s_pr;
    end else if (s_cm) begin
      m_pend = 1'b1;
      m_prst = m_prst | s_pr;
    end
  endtask

  task automatic compare_outputs();
    check("out_valid", longint'(out_valid), longint'(m_ov), 0);
    check("cfg_pending", longint'(cfg_pending), longint'(m_pend), 0);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("out_i[%0d]", c), longint'($signed(out_i[c*DSZ +: DSZ])), longint'(m_oi[c]), 1);
      check($sformatf("out_q[%0d]", c), longint'($signed(out_q[c*DSZ +: DSZ])), longint'(m_oq[c]), 1);
    end
  endtask

  // One clock: check what the last edge produced, drive the next, step model.
  task automatic tick();
    @(negedge clk);
    compare_outputs();
    reset       = s_rst;
    in_valid    = s_iv;
    in          = DSZ'(s_in);
    lo_ns_en    = s_ns;
    cfg_wr      = s_wr;
    cfg_ch      = CHW'(s_ch);
    cfg_freq    = FSZ'(s_f);
    cfg_phase   = PSZ'(s_p);
    cfg_commit  = s_cm;
    cfg_phs_rst = s_pr;
    model_step();
    s_rst = 1'b0; s_wr = 1'b0; s_cm = 1'b0; s_pr = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input longint f, input int p);
    s_wr = 1'b1; s_ch = ch; s_f = f; s_p = p;
  endtask

  initial begin
    model_reset();
    s_rst = 1'b1; tick();
    s_rst = 1'b1; tick();

    // No configuration, constant 1000: all channels at phase zero.
    s_iv = 1'b1; s_in = 1000;
    repeat (10) tick();

    // Channel 1 at a quarter of the sample rate.
    write_cfg(1, 64'sd1 <<< (FSZ - 2), 0); tick();
    s_cm = 1'b1; tick();
    repeat (12) tick();

    // Channel 0 offset by 90 degrees with phase reset, full-scale negative input.
    write_cfg(0, 0, 1 << (PSZ - 2)); s_cm = 1'b1; s_pr = 1'b1; s_in = -32768; tick();
    repeat (10) tick();

    // Commit while idle; the first accepted sample also writes a new shadow value.
    s_iv = 1'b0;
    write_cfg(2, 12345, 77); tick();
    s_cm = 1'b1; tick();
    repeat (10) tick();
    s_iv = 1'b1; s_in = 20000; write_cfg(2, 999, 5); tick();
    repeat (8) tick();

    // Bubble pattern, then reset with samples in flight.
    for (int r = 0; r < 2; r++) begin
      s_iv = 1'b1; tick(); s_iv = 1'b0; tick();
      s_iv = 1'b1; tick(); s_iv = 1'b1; tick(); s_iv = 1'b0; tick();
    end
    s_iv = 1'b1; tick(); tick();
    s_cm = 1'b1; tick();
    s_iv = 1'b0; s_rst = 1'b1; tick();
    repeat (7) tick();
    s_iv = 1'b1; s_in = -1234; repeat (8) tick();

    // Small and wrapping tuning words with noise shaping toggled.
    write_cfg(2, 1, 0); tick();
    write_cfg(3, FMASK, 100); tick();
    write_cfg(1, (FMASK / 3) + 1, 0); tick();
    s_cm = 1'b1; s_pr = 1'b1; tick();
    for (int k = 0; k < 40; k++) begin
      if (k % 5 == 0) s_ns = ~s_ns;
      s_in = 30000 - 1500 * k;
      tick();
    end

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      s_iv = ($urandom_range(0, 9) < 7);
      s_in = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 19) == 0) s_ns = ~s_ns;
      if ($urandom_range(0, 3) == 0) begin
        s_wr = 1'b1;
        s_ch = $urandom_range(0, NCH - 1);
        s_f  = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 4095))
                                           : (longint'($urandom) & FMASK);
        s_p  = $urandom_range(0, (1 << PSZ) - 1);
      end
      s_cm  = ($urandom_range(0, 19) == 0);
      s_pr  = ($urandom_range(0, 2) == 0);
      s_rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    s_iv = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
